// File: rtl/mode_sequencer_if.sv
// Switch/engine inputs and mode/enable outputs of the mode sequencer.
// The master side drives the raw switches and the engine busy flag; the
// slave side (the sequencer) returns the mode code and function enables.
interface mode_sequencer_if;
    logic [3:0] dipsw_n_i;
    logic       pushsw_n_i;
    logic       scard_busy_i;
    logic [1:0] mode_o;
    logic       openadc_disable_o;
    logic       spi_flash_en_o;
    logic       card_writer_en_o;
    logic       ready_o;
    logic       timeout_o;

    modport master (
        output dipsw_n_i, pushsw_n_i, scard_busy_i,
        input  mode_o, openadc_disable_o, spi_flash_en_o, card_writer_en_o,
               ready_o, timeout_o
    );

    modport slave (
        input  dipsw_n_i, pushsw_n_i, scard_busy_i,
        output mode_o, openadc_disable_o, spi_flash_en_o, card_writer_en_o,
               ready_o, timeout_o
    );
endinterface

// File: rtl/mode_sequencer.sv
// Mode sequencer: synchronises and debounces the DIP/push switches, decodes
// the requested operating mode, and moves between modes through a drain
// phase (wait for the smartcard engine to go idle, bounded by a timeout)
// and a settle phase (everything disabled) before enabling the new mode.
module mode_sequencer #(
    parameter int DEBOUNCE_CYCLES = 1024,
    parameter int DRAIN_TIMEOUT   = 256,
    parameter int SETTLE_CYCLES   = 64
) (
    input  logic             clk,
    input  logic             reset_i,
    mode_sequencer_if.slave  bus
);
    localparam int DEB_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int DRN_W = $clog2(DRAIN_TIMEOUT) + 1;
    localparam int STL_W = $clog2(SETTLE_CYCLES) + 1;

    localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DRN_W-1:0] DRAIN_LAST = DRN_W'(DRAIN_TIMEOUT - 1);
    localparam logic [STL_W-1:0] STL_LAST   = STL_W'(SETTLE_CYCLES - 1);

    localparam logic [1:0] MODE_OPENADC = 2'b00;
    localparam logic [1:0] MODE_SPI     = 2'b01;
    localparam logic [1:0] MODE_WRITER  = 2'b10;
    localparam logic [1:0] MODE_TRANS   = 2'b11;

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    // Registered output bundle: {mode, openadc_disable, spi_en, writer_en, ready}
    typedef struct packed {
        logic [1:0] mode;
        logic       disable_adc;
        logic       spi_en;
        logic       writer_en;
        logic       ready;
    } outs_t;

    localparam outs_t TRANS_OUTS = '{mode: MODE_TRANS, disable_adc: 1'b1,
                                     spi_en: 1'b0, writer_en: 1'b0, ready: 1'b0};

    function automatic outs_t active_outs(input logic [1:0] t);
        outs_t o;
        o.mode        = t;
        o.disable_adc = (t != MODE_OPENADC);
        o.spi_en      = (t == MODE_SPI);
        o.writer_en   = (t == MODE_WRITER);
        o.ready       = 1'b1;
        return o;
    endfunction

    logic [4:0]       sync1_q, sync2_q;
    logic [4:0]       cand_q, deb_q;
    logic [DEB_W-1:0] deb_cnt_q;
    logic             push_prev_q;

    state_t           state_q;
    logic [1:0]       target_q;
    logic [DRN_W-1:0] drain_cnt_q;
    logic [STL_W-1:0] settle_cnt_q;
    logic             timeout_q;
    outs_t            outs_q;

    logic [1:0]       decoded_mode;
    logic             restart_pulse;

    // Two-flop synchroniser for the raw switch vector {push, dip[3:0]}
    always_ff @(posedge clk) begin
        if (reset_i) begin
            sync1_q <= 5'b11111;
            sync2_q <= 5'b11111;
        end else begin
            sync1_q <= {bus.pushsw_n_i, bus.dipsw_n_i};
            sync2_q <= sync1_q;
        end
    end

    // Whole-vector debounce; any bit change restarts the stability count,
    // and the count holds at its last value instead of wrapping
    always_ff @(posedge clk) begin
        if (reset_i) begin
            cand_q      <= 5'b11111;
            deb_q       <= 5'b11111;
            deb_cnt_q   <= '0;
            push_prev_q <= 1'b1;
        end else begin
            push_prev_q <= deb_q[4];
            if (sync2_q != cand_q) begin
                cand_q    <= sync2_q;
                deb_cnt_q <= '0;
            end else if (deb_cnt_q == DEB_LAST) begin
                deb_q <= cand_q;
            end else begin
                deb_cnt_q <= deb_cnt_q + DEB_W'(1);
            end
        end
    end

    // Mode decode with writer over SPI over OpenADC; restart on push press
    always_comb begin
        if (!deb_q[2])      decoded_mode = MODE_WRITER;
        else if (!deb_q[3]) decoded_mode = MODE_SPI;
        else                decoded_mode = MODE_OPENADC;
        restart_pulse = push_prev_q & ~deb_q[4];
    end

    // Sequencing FSM; outputs are loaded on the edge that enters each state
    always_ff @(posedge clk) begin
        if (reset_i) begin
            state_q      <= ST_SETTLE;
            target_q     <= MODE_OPENADC;
            drain_cnt_q  <= '0;
            settle_cnt_q <= '0;
            timeout_q    <= 1'b0;
            outs_q       <= TRANS_OUTS;
        end else begin
            case (state_q)
                ST_ACTIVE: begin
                    if ((decoded_mode != target_q) || restart_pulse) begin
                        target_q    <= decoded_mode;
                        state_q     <= ST_DRAIN;
                        drain_cnt_q <= '0;
                        outs_q      <= TRANS_OUTS;
                    end
                end
                ST_DRAIN: begin
                    // A new request retargets but does not extend the drain window
                    if (decoded_mode != target_q)
                        target_q <= decoded_mode;
                    if (!bus.scard_busy_i || (drain_cnt_q == DRAIN_LAST)) begin
                        state_q      <= ST_SETTLE;
                        settle_cnt_q <= '0;
                        if (bus.scard_busy_i)
                            timeout_q <= 1'b1;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + DRN_W'(1);
                    end
                end
                ST_SETTLE: begin
                    if (decoded_mode != target_q) begin
                        target_q     <= decoded_mode;
                        settle_cnt_q <= '0;
                    end else if (settle_cnt_q == STL_LAST) begin
                        state_q <= ST_ACTIVE;
                        outs_q  <= active_outs(target_q);
                    end else begin
                        settle_cnt_q <= settle_cnt_q + STL_W'(1);
                    end
                end
                default: begin
                    state_q      <= ST_SETTLE;
                    settle_cnt_q <= '0;
                    outs_q       <= TRANS_OUTS;
                end
            endcase
        end
    end

    assign bus.mode_o            = outs_q.mode;
    assign bus.openadc_disable_o = outs_q.disable_adc;
    assign bus.spi_flash_en_o    = outs_q.spi_en;
    assign bus.card_writer_en_o  = outs_q.writer_en;
    assign bus.ready_o           = outs_q.ready;
    assign bus.timeout_o         = timeout_q;
endmodule

// File: doc/mode_sequencer.md
MODE_SEQUENCER -- requirements
Module: mode_sequencer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1024: consecutive stable cycles before a switch change is accepted.
REQ-002 Parameter DRAIN_TIMEOUT, default 256: maximum cycles spent waiting for the smartcard engine to go idle.
REQ-003 Parameter SETTLE_CYCLES, default 64: cycles all functions stay disabled before the new mode is applied.
REQ-004 clk  in  1  single clock for the block.
REQ-005 reset_i  in  1  synchronous, active-high reset.
REQ-006 dipsw_n_i  in  4  raw DIP switches, active-low, asynchronous.
REQ-007 pushsw_n_i  in  1  raw push switch, active-low, asynchronous; requests a restart of the current mode.
REQ-008 scard_busy_i  in  1  smartcard/USI engine busy (clk domain).
REQ-009 mode_o  out  2  mode code: 00 OpenADC, 01 SPI flash, 10 card writer, 11 in transition.
REQ-010 openadc_disable_o  out  1  holds OpenADC and the register-bus slaves in reset.
REQ-011 spi_flash_en_o  out  1  enables SPI flash passthrough.
REQ-012 card_writer_en_o  out  1  enables card-writer passthrough.
REQ-013 ready_o  out  1  high only in ACTIVE.
REQ-014 timeout_o  out  1  sticky flag: a drain ended by timeout.

Function
REQ-015 {pushsw_n_i, dipsw_n_i} (5 bits) SHALL pass through a 2-flop synchronizer.
REQ-016 Debounce, whole vector: if sync != candidate -> candidate <= sync, cnt <= 0; else if cnt == DEBOUNCE_CYCLES-1 -> deb <= candidate; else cnt++.
REQ-017 Decode from deb, with priority: dipsw[2]==0 -> card writer; else dipsw[3]==0 -> SPI flash; else OpenADC.
REQ-018 Restart request SHALL be a single-cycle pulse on the 1->0 transition of deb pushsw bit.
REQ-019 States SHALL be ACTIVE, DRAIN and SETTLE; register target holds the mode to apply.
REQ-020 ACTIVE -> DRAIN when decoded mode != target (target <= decoded) or on a restart pulse (target unchanged).
REQ-021 DRAIN SHALL last at least 1 cycle, then go to SETTLE in the first cycle where scard_busy_i==0 or drain_cnt==DRAIN_TIMEOUT-1.
REQ-022 If DRAIN exits on the timeout with scard_busy_i==1 in that cycle, timeout_o SHALL set (the busy exit takes precedence when both hold).
REQ-023 SETTLE SHALL count SETTLE_CYCLES cycles, then go to ACTIVE.
REQ-024 If the decoded mode changes while in DRAIN or SETTLE, target SHALL update; in SETTLE settle_cnt SHALL restart at 0; in DRAIN the drain count SHALL continue.
REQ-025 A restart pulse in DRAIN or SETTLE SHALL be ignored.
REQ-026 Outputs in ACTIVE: mode_o=target, openadc_disable_o=(target!=OpenADC), spi_flash_en_o=(target==SPI), card_writer_en_o=(target==writer), ready_o=1.
REQ-027 Outputs in DRAIN/SETTLE: mode_o=11, openadc_disable_o=1, both enables 0, ready_o=0.
REQ-028 All outputs SHALL be registered; spi_flash_en_o and card_writer_en_o SHALL never be high in the same cycle.
REQ-029 Counters SHALL be $clog2(max)+1 bits wide and SHALL saturate, never wrap.
REQ-030 Latency from a stable switch change to the new ACTIVE mode = 2 (sync) + DEBOUNCE_CYCLES + DRAIN cycles + SETTLE_CYCLES, +-1 cycle for registration.

Reset
REQ-031 reset_i SHALL set: state=SETTLE, target=OpenADC, sync/candidate/deb=5'b11111, all counters 0, timeout_o=0.
REQ-032 In the cycle after reset_i, outputs SHALL be mode_o=11, openadc_disable_o=1, both enables 0, ready_o=0.
REQ-033 Reset asserted mid-DRAIN or mid-SETTLE SHALL abort the sequence and apply REQ-031 on the next edge.

Verification (DEBOUNCE_CYCLES=4, DRAIN_TIMEOUT=8, SETTLE_CYCLES=4)
REQ-034 Release reset, switches all 1 -> mode_o=11 for 4 cycles, then mode_o=00, openadc_disable_o=0, ready_o=1.
REQ-035 dipsw_n_i=4'b1011, busy=0 -> after sync+debounce, 1 DRAIN cycle + 4 SETTLE cycles, then mode_o=10 and card_writer_en_o=1.
REQ-036 dipsw_n_i=4'b0011 -> writer wins priority: mode_o=10, spi_flash_en_o=0.
REQ-037 Switch to SPI with busy held 1 -> DRAIN exactly 8 cycles, timeout_o=1 (sticky), then mode_o=01.
REQ-038 A 3-cycle glitch on dipsw_n_i[3] -> no state change; a pushsw press in ACTIVE -> DRAIN/SETTLE, then the same mode returns.
REQ-039 Change the switch during SETTLE cycle 2 -> SETTLE restarts, final mode equals the latest switch setting; reset during SETTLE -> REQ-032 values.
